// File: rtl/sobol_gen.sv
// Sobol quasi-random point generator (1-D, Gray-code recurrence) producing Q16.16 u values.
// Optional digital-shift scrambling is built only when SOBOL_SCRAMBLE_EN is defined.

package fpga_cfg_pkg;
    localparam int FP_WIDTH = 32;
    localparam int FP_QFRAC = 16;
endpackage

module sobol_gen #(
    parameter int WIDTH      = fpga_cfg_pkg::FP_WIDTH,
    parameter int QFRAC      = fpga_cfg_pkg::FP_QFRAC,
    parameter int NUM_POINTS = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir_we,
    input  logic [3:0]       dir_addr,
    input  logic [15:0]      dir_data,
    input  logic [15:0]      scramble,
    input  logic             ready_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] u,
    output logic [15:0]      index,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [QFRAC-1:0]   x_q, x_d;
    logic [15:0]        n_q, n_d;
    logic [QFRAC-1:0]   v_q [16];
    logic [QFRAC-1:0]   v_d [16];
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   u_q, u_d;
    logic [15:0]        index_q, index_d;

    logic               in_idle;
    logic [QFRAC-1:0]   x_base, step_x, frac;
    logic [15:0]        n_base, step_n;
    logic               fire;

    // 16-bit direction words are left-aligned into the QFRAC-bit fraction.
    function automatic logic [QFRAC-1:0] left_align(input logic [15:0] d);
        return QFRAC'({d, {QFRAC{1'b0}}} >> 16);
    endfunction

    function automatic logic [3:0] lowest_zero(input logic [15:0] val);
        logic [3:0] pos;
        pos = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (!val[i]) pos = 4'(i);
        end
        return pos;
    endfunction

    // The start cycle computes point 1 from a cleared x/n, giving valid one cycle after start.
    always_comb begin
        in_idle = (state_q == ST_IDLE);
        x_base  = in_idle ? '0 : x_q;
        n_base  = in_idle ? '0 : n_q;
        step_x  = x_base ^ v_q[lowest_zero(n_base)];
        step_n  = n_base + 16'd1;
    end

`ifdef SOBOL_SCRAMBLE_EN
    logic [QFRAC-1:0] scr_q, scr_d, mixed;

    always_comb begin
        scr_d = scr_q;
        if (in_idle && start) scr_d = left_align(scramble);
        mixed = step_x ^ (in_idle ? left_align(scramble) : scr_q);
        frac  = (mixed == '0) ? QFRAC'(1) : mixed;
    end

    always_ff @(posedge clk) begin
        if (rst) scr_q <= '0;
        else     scr_q <= scr_d;
    end
`else
    logic unused_scramble;
    assign unused_scramble = ^scramble;
    assign frac = step_x;
`endif

    // Output handshake: a point transfers on a cycle with valid_out && ready_in;
    // while valid_out is high and ready_in low, u/index hold and the sequence stalls.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        n_d     = n_q;
        v_d     = v_q;
        valid_d = valid_q;
        u_d     = u_q;
        index_d = index_q;
        fire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dir_we) v_d[dir_addr] = left_align(dir_data);
                if (start) begin
                    fire    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (valid_q && ready_in && index_q == 16'(NUM_POINTS)) begin
                    valid_d = 1'b0;
                    state_d = ST_DONE;
                end else if ((!valid_q || ready_in) && n_q < 16'(NUM_POINTS)) begin
                    fire = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (fire) begin
            x_d     = step_x;
            n_d     = step_n;
            u_d     = WIDTH'(frac);
            index_d = step_n;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            n_q     <= '0;
            valid_q <= 1'b0;
            u_q     <= '0;
            index_q <= '0;
            for (int k = 0; k < 16; k++) v_q[k] <= left_align(16'h8000 >> k);
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            n_q     <= n_d;
            valid_q <= valid_d;
            u_q     <= u_d;
            index_q <= index_d;
            v_q     <= v_d;
        end
    end

    assign valid_out = valid_q;
    assign u         = u_q;
    assign index     = index_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_sobol_gen.sv
// Bench for sobol_gen: random runs checked against a Gray-code Sobol reference model.
// Define SOBOL_SCRAMBLE_EN for both bench and design to cover the scrambled build.

module tb_sobol_gen;
  localparam int NP = 4;

  logic        clk = 1'b0;
  logic        rst, start, dir_we, ready_in;
  logic [3:0]  dir_addr;
  logic [15:0] dir_data, scramble;
  logic        valid_out, busy, done;
  logic [31:0] u;
  logic [15:0] index;

  logic [15:0] v_m [16];
  logic [15:0] scr_m;
  logic [31:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  sobol_gen #(.WIDTH(32), .QFRAC(16), .NUM_POINTS(NP)) dut (
    .clk(clk), .rst(rst), .start(start), .dir_we(dir_we), .dir_addr(dir_addr),
    .dir_data(dir_data), .scramble(scramble), .ready_in(ready_in),
    .valid_out(valid_out), .u(u), .index(index), .busy(busy), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // reference: point n is the XOR of v[i] over the set bits of gray(n)
  function automatic logic [31:0] sobol_ref(input int n);
    logic [15:0] g, x;
    g = 16'(n ^ (n >> 1));
    x = 16'h0000;
    for (int i = 0; i < 16; i++) if (g[i]) x = x ^ v_m[i];
`ifdef SOBOL_SCRAMBLE_EN
    x = x ^ scr_m;
    if (x == 16'h0000) x = 16'h0001;
`endif
    return {16'h0000, x};
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 16; k++) v_m[k] = 16'h8000 >> k;
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write_dir(input logic [3:0] a, input logic [15:0] d);
    dir_we = 1'b1; dir_addr = a; dir_data = d;
    cycle();
    dir_we = 1'b0;
    v_m[a] = d;
  endtask

  // mode 0: ready always high, 1: ready low for first 3 cycles, 2: random ready
  task automatic do_run(input int mode, input bit fill, input bit poke);
    int got;
    int cyc;
    scr_m = scramble;
    if (fill) for (int k = 1; k <= NP; k++) exp_q.push_back(sobol_ref(k));
    start = 1'b1;
    cycle();
    start = 1'b0;
    got = 0;
    cyc = 0;
    while (got < NP && cyc < 200) begin
      case (mode)
        0:       ready_in = 1'b1;
        1:       ready_in = (cyc >= 3);
        default: ready_in = ($urandom_range(0, 99) < 60);
      endcase
      if (poke) begin
        start    = 1'($urandom_range(0, 1));
        dir_we   = 1'($urandom_range(0, 1));
        dir_addr = 4'($urandom_range(0, 2));
        dir_data = 16'($urandom);
      end
      @(negedge clk);
      check("valid", valid_out, 1);
      check("busy", busy, 1);
      if (exp_q.size() > 0) begin
        check("u", u, exp_q[0]);
        check("index", index, 32'(got + 1));
      end
      if (valid_out && ready_in) begin
        void'(exp_q.pop_front());
        got++;
      end
      cycle();
      cyc++;
    end
    start  = 1'b0;
    dir_we = 1'b0;
    check("points", got, NP);
    if (mode == 0) check("cycles", cyc, NP);
    if (poke) start = 1'b1;
    @(negedge clk);
    check("done_pulse", done, 1);
    check("valid_end", valid_out, 0);
    check("busy_end", busy, 0);
    cycle();
    start = 1'b0;
    @(negedge clk);
    check("done_once", done, 0);
    check("idle_busy", busy, 0);
    check("idle_valid", valid_out, 0);
    cycle();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dir_we = 1'b0; dir_addr = 4'd0;
    dir_data = 16'h0000; scramble = 16'h0000; ready_in = 1'b0;
    reset_model();
    repeat (2) cycle();
    @(negedge clk);
    check("rst_valid", valid_out, 0);
    check("rst_u", u, 0);
    check("rst_index", index, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    cycle();

    // default direction numbers, full-rate run
    exp_q.push_back(32'h0000_8000);
    exp_q.push_back(32'h0000_C000);
    exp_q.push_back(32'h0000_4000);
    exp_q.push_back(32'h0000_6000);
    do_run(0, 1'b0, 1'b0);

    // downstream stall right after the first point
    do_run(1, 1'b1, 1'b0);

    // IDLE write of v[0], then start/dir_we pokes during RUN and DONE
    write_dir(4'd0, 16'hC000);
    do_run(0, 1'b1, 1'b1);

    // randomized direction numbers, seeds and backpressure
    repeat (8) begin
      repeat ($urandom_range(1, 3)) write_dir(4'($urandom_range(0, 3)), 16'($urandom_range(1, 65535)));
      scramble = 16'($urandom);
      do_run(2, 1'b1, 1'($urandom_range(0, 1)));
    end
    scramble = 16'h0000;

`ifdef SOBOL_SCRAMBLE_EN
    write_dir(4'd0, 16'h8000);
    write_dir(4'd1, 16'h4000);
    scramble = 16'h8000;
    scr_m = scramble;
    exp_q.push_back(32'h0000_0001);
    exp_q.push_back(32'h0000_4000);
    exp_q.push_back(sobol_ref(3));
    exp_q.push_back(sobol_ref(4));
    do_run(0, 1'b0, 1'b0);
    scramble = 16'h0000;
`endif

    // reset in the middle of a run
    write_dir(4'd0, 16'hC000);
    scr_m = scramble;
    start = 1'b1;
    ready_in = 1'b1;
    cycle();
    start = 1'b0;
    @(negedge clk);
    check("mid_u1", u, sobol_ref(1));
    cycle();
    @(negedge clk);
    check("mid_u2", u, sobol_ref(2));
    rst = 1'b1;
    cycle();
    @(negedge clk);
    check("abort_valid", valid_out, 0);
    check("abort_u", u, 0);
    check("abort_index", index, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    rst = 1'b0;
    reset_model();
    repeat (4) begin
      cycle();
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    cycle();

    // fresh run restarts from the default direction numbers
    do_run(0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sobol_gen.md
SOBOL_GEN -- requirements
Module: sobol_gen

Interface
REQ-001 SHALL have parameter WIDTH, default fpga_cfg_pkg::FP_WIDTH (32), the output word width.
REQ-002 SHALL have parameter QFRAC, default fpga_cfg_pkg::FP_QFRAC (16), the fractional bits of u; the direction numbers are QFRAC bits wide.
REQ-003 SHALL have parameter NUM_POINTS, default 4096, the points per run; the legal range is 1..65535.
REQ-004 clk  in  1  the single clock; all logic is rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begins a run; sampled only in IDLE.
REQ-007 dir_we  in  1  direction-number write strobe.
REQ-008 dir_addr  in  4  direction-number index k.
REQ-009 dir_data  in  16  direction number v[k], left-aligned fraction.
REQ-010 scramble  in  16  digital-shift seed; used only when the configuration macro is defined.
REQ-011 ready_in  in  1  downstream (inverse-CDF step 1) accepts u.
REQ-012 valid_out  out  1  u is valid.
REQ-013 u  out  WIDTH  Sobol point in Q16.16, range (0,1).
REQ-014 index  out  16  sequence index n of the current u.
REQ-015 busy  out  1  high in RUN.
REQ-016 done  out  1  one-cycle pulse when a run completes.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE; IDLE SHALL move to RUN on start, RUN SHALL move to DONE on the final handshake, and DONE SHALL move to IDLE after one cycle.
REQ-018 A direction write (dir_we) SHALL store dir_data into v[dir_addr] only in IDLE; writes in RUN or DONE SHALL be ignored.
REQ-019 When start is accepted, the block SHALL clear the state x and the counter n to 0 in the same cycle.
REQ-020 Generation step: c = index of the lowest zero bit of n; x_next = x XOR v[c]; n_next = n+1.
REQ-021 Point n=0 (value 0) SHALL never be emitted; the first emitted point SHALL be n=1.
REQ-022 A step SHALL fire in RUN when (!valid_out || ready_in) and fewer than NUM_POINTS points have been generated; the step SHALL register u = {zeros, x_next} (x_next in the low QFRAC bits), index = n_next and valid_out = 1.
REQ-023 Latency: with start accepted in cycle T, valid_out SHALL be high in cycle T+1, and throughput SHALL be one point per cycle while ready_in=1.
REQ-024 While valid_out=1 and ready_in=0, u and index SHALL hold stable and x and n SHALL not advance.
REQ-025 On the handshake of point NUM_POINTS, valid_out SHALL drop the next cycle, the FSM SHALL enter DONE, and done SHALL be 1 for exactly that cycle.
REQ-026 start while busy SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-027 busy SHALL be 1 exactly in RUN.
REQ-028 The upper WIDTH-QFRAC bits of u SHALL always be 0.

Reset
REQ-029 While rst=1: state=IDLE; valid_out, u, index, busy, done, x and n = 0; v[k] = 1<<(15-k) (van der Corput defaults).
REQ-030 Reset mid-run SHALL abort the run immediately, with no done pulse, and SHALL restore the default direction numbers.

Configuration
REQ-031 Macro SOBOL_SCRAMBLE_EN: when defined, the emitted fraction SHALL be x_next XOR scramble (sampled at start and held for the run); a result of 0 SHALL be replaced by 0x0001 so that u is never 0.
REQ-032 When SOBOL_SCRAMBLE_EN is undefined, the scramble port SHALL be ignored and no scramble logic SHALL be synthesized.

Verification
REQ-033 Default table, NUM_POINTS=4, ready_in=1, start -> u = 0x00008000, 0x0000C000, 0x00004000, 0x00006000 with index 1..4 on consecutive cycles, then a done pulse and busy=0.
REQ-034 ready_in held low 3 cycles after the first valid -> u held at 0x00008000 and index=1 for those cycles; the next point is 0x0000C000 after ready_in rises.
REQ-035 In IDLE write v[0]=0xC000, then start -> first u = 0x0000C000; a dir_we issued during RUN has no effect on later points.
REQ-036 SOBOL_SCRAMBLE_EN defined, scramble=0x8000 -> first u = 0x00000001 (zero substitution), second u = 0x00004000.
REQ-037 rst asserted at point 2 of 4 -> all outputs 0 the next cycle, no done pulse; a fresh start restarts at u=0x00008000.
REQ-038 start pulsed during RUN and during DONE -> no restart; the sequence completes normally.
